// File: rtl/mbgd_pkg.sv
// Shared defaults and arithmetic helpers for the mini-batch gradient accumulator.
package mbgd_pkg;

  localparam int unsigned DW_DEF         = 8;
  localparam int unsigned N_DEF          = 8;
  localparam int unsigned N_BIT_DEF      = 3;
  localparam int unsigned BATCH_BITS_DEF = 4;
  localparam int unsigned OUT_W_DEF      = 8;
  localparam int unsigned SH_W_DEF       = 5;

  // Product width plus tree growth plus headroom for a full mini-batch.
  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned n_bit,
                                        input int unsigned batch_bits);
    return 2 * dw + 1 + n_bit + batch_bits;
  endfunction

  // Arithmetic right shift with round-half-toward-+inf; 64 bits leaves room for the bias.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] t,
                                                     input int unsigned sh);
    logic signed [63:0] r;
    r = t;
    if (sh != 0) r = t + (64'sd1 <<< (sh - 1));
    return r >>> sh;
  endfunction

  // True when q does not fit an ow-bit two's-complement word.
  function automatic logic sat_check(input logic signed [63:0] q, input int unsigned ow);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    return (q > hi) || (q < -(hi + 64'sd1));
  endfunction

endpackage

// File: rtl/mbgd_lane_tree.sv
// Stages S1-S3: lane differences, lane products, and the lane sum, all gated by advance.
module mbgd_lane_tree
  import mbgd_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned N_BIT = N_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      advance,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [DW*N-1:0]           x_col,
  input  logic [DW*N-1:0]           h,
  input  logic [DW*N-1:0]           y,
  output logic                      s_valid,
  output logic                      s_last,
  output logic signed [2*DW+N_BIT:0] s
);

  localparam int unsigned PW = 2 * DW + 1;
  localparam int unsigned SW = PW + N_BIT;

  logic [DW-1:0]        x1 [N];
  logic signed [DW:0]   d1 [N];
  logic signed [PW-1:0] p2 [N];
  logic                 v1, l1, v2, l2;
  logic signed [SW-1:0] sum_c;

  // S1: capture x and h-y per lane
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        x1[i] <= '0;
        d1[i] <= '0;
      end
    end else if (advance) begin
      v1 <= in_valid;
      l1 <= in_last;
      for (int unsigned i = 0; i < N; i++) begin
        x1[i] <= x_col[DW*i +: DW];
        d1[i] <= $signed({1'b0, h[DW*i +: DW]}) - $signed({1'b0, y[DW*i +: DW]});
      end
    end
  end

  // S2: x is non-negative, so |x*d| < 2^(2*DW) and the product fits PW bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v2 <= 1'b0;
      l2 <= 1'b0;
      for (int unsigned i = 0; i < N; i++) p2[i] <= '0;
    end else if (advance) begin
      v2 <= v1;
      l2 <= l1;
      for (int unsigned i = 0; i < N; i++)
        p2[i] <= PW'($signed({1'b0, x1[i]})) * PW'(d1[i]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < N; i++) sum_c = sum_c + SW'(p2[i]);
  end

  // S3: register the sign-extended lane sum
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s       <= '0;
    end else if (advance) begin
      s_valid <= v2;
      s_last  <= l2;
      s       <= sum_c;
    end
  end

endmodule

// File: rtl/mbgd_grad_accum.sv
// Mini-batch gradient accumulator: lane tree, batch accumulator, scaling/saturation, handshake.
module mbgd_grad_accum
  import mbgd_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned N          = N_DEF,
  parameter int unsigned N_BIT      = N_BIT_DEF,
  parameter int unsigned BATCH_BITS = BATCH_BITS_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned SH_W       = SH_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [DW*N-1:0]         x_col,
  input  logic [DW*N-1:0]         h,
  input  logic [DW*N-1:0]         y,
  input  logic [SH_W-1:0]         shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] g,
  output logic                    g_sat,
  output logic                    ovf
);

  localparam int unsigned ACC_W = acc_w(DW, N_BIT, BATCH_BITS);
  localparam int unsigned SW    = 2 * DW + 1 + N_BIT;
  localparam int unsigned CW    = BATCH_BITS + 1;
  localparam logic [OUT_W-1:0] G_MIN = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic [OUT_W-1:0] G_MAX = ~G_MIN;

  logic                    advance;
  logic                    s_valid, s_last;
  logic signed [SW-1:0]    s;
  logic signed [ACC_W-1:0] acc, t;
  logic signed [63:0]      q;
  logic                    sat;
  logic [CW-1:0]           cnt;

  // The whole pipeline moves only when the output slot can take a result.
  assign advance  = enable & ~(out_valid & ~out_ready);
  assign in_ready = advance;

  mbgd_lane_tree #(.DW(DW), .N(N), .N_BIT(N_BIT)) u_tree (
    .clk     (clk),
    .resetn  (resetn),
    .advance (advance),
    .in_valid(in_valid),
    .in_last (in_last),
    .x_col   (x_col),
    .h       (h),
    .y       (y),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s       (s)
  );

  assign t   = acc + ACC_W'(s);
  assign q   = round_shift(64'(t), 32'(shift));
  assign sat = sat_check(q, OUT_W);

  // Beat counter saturates at 2^BATCH_BITS so any further beat in the batch flags ovf.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (advance && in_valid) begin
      if (cnt[BATCH_BITS]) ovf <= 1'b1;
      if (in_last) cnt <= '0;
      else if (!cnt[BATCH_BITS]) cnt <= cnt + CW'(1);
    end
  end

  // S4: accumulate, and on the last beat emit the scaled, clamped result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc       <= '0;
      out_valid <= 1'b0;
      g         <= '0;
      g_sat     <= 1'b0;
    end else if (advance) begin
      if (s_valid) acc <= s_last ? '0 : t;
      out_valid <= s_valid & s_last;
      if (s_valid && s_last) begin
        g     <= sat ? (q[63] ? G_MIN : G_MAX) : q[OUT_W-1:0];
        g_sat <= sat;
      end
    end
  end

endmodule

// File: tb/tb_mbgd_grad_accum.sv
// Directed bench for mbgd_grad_accum with a scoreboard of expected batch results.
module tb_mbgd_grad_accum;

  logic        clk = 1'b0;
  logic        resetn, enable, in_valid, in_ready, in_last;
  logic [63:0] x_col, h, y;
  logic [4:0]  shift;
  logic        out_valid, out_ready, g_sat, ovf;
  logic [7:0]  g;

  int          vectors = 0;
  int          errs    = 0;
  longint      model_acc = 0;
  logic [8:0]  sb [$];

  always #5 clk = ~clk;

  mbgd_grad_accum dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .x_col    (x_col),
    .h        (h),
    .y        (y),
    .shift    (shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .g        (g),
    .g_sat    (g_sat),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic longint beat_sum(input logic [63:0] xv, input logic [63:0] hv,
                                      input logic [63:0] yv);
    longint acc;
    acc = 0;
    for (int i = 0; i < 8; i++)
      acc += longint'(xv[8*i +: 8]) * (longint'(hv[8*i +: 8]) - longint'(yv[8*i +: 8]));
    return acc;
  endfunction

  // Expected {g_sat, g}: floor((t + half) / 2^sh), clamped to 8-bit signed.
  function automatic logic [8:0] expect_g(input longint t, input int sh);
    longint r, q;
    r = t;
    if (sh > 0) r = t + (longint'(1) <<< (sh - 1));
    q = r >>> sh;
    if (q > 127) return {1'b1, 8'h7f};
    if (q < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(q)};
  endfunction

  // Drive one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic beat(input logic [63:0] xv, input logic [63:0] hv, input logic [63:0] yv,
                      input logic last, input int sh);
    int n;
    longint bs;
    in_valid = 1'b1;
    in_last  = last;
    x_col    = xv;
    h        = hv;
    y        = yv;
    shift    = 5'(sh);
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    bs = beat_sum(xv, hv, yv);
    if (last) begin
      sb.push_back(expect_g(model_acc + bs, sh));
      model_acc = 0;
    end else begin
      model_acc += bs;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: compare each result as it is handed downstream.
  always @(negedge clk) begin
    logic [8:0] e;
    #1;
    if (resetn && out_valid && out_ready && enable) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("g", 64'(g), 64'(e[7:0]));
        check("g_sat", 64'(g_sat), 64'(e[8]));
      end
    end
  end

  initial begin
    int n;
    resetn = 1'b0; enable = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    x_col = '0; h = '0; y = '0; shift = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_g", 64'(g), 64'd0);
    check("rst_g_sat", 64'(g_sat), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Single-beat batch with latency, then a back-to-back repeat
    beat(rep(8'd1), rep(8'd10), rep(8'd4), 1'b1, 0);
    check("lat_k0", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_k1", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_k2", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_k3", 64'(out_valid), 64'd1);
    wait_drain();
    beat(rep(8'd1), rep(8'd10), rep(8'd4), 1'b1, 0);
    beat(rep(8'd1), rep(8'd10), rep(8'd4), 1'b1, 0);
    wait_drain();

    // Two-beat batches at shift 0 and 1
    beat(rep(8'd2), rep(8'd5), rep(8'd9), 1'b0, 0);
    beat(rep(8'd2), rep(8'd5), rep(8'd9), 1'b1, 0);
    wait_drain();
    beat(rep(8'd2), rep(8'd5), rep(8'd9), 1'b0, 1);
    beat(rep(8'd2), rep(8'd5), rep(8'd9), 1'b1, 1);
    wait_drain();

    // Saturation and rounding
    beat(rep(8'd255), rep(8'd255), rep(8'd0), 1'b1, 0);
    wait_drain();
    beat(rep(8'd255), rep(8'd255), rep(8'd0), 1'b1, 12);
    wait_drain();

    // Negative rounding: t = -3, shift 1
    beat(64'h3, 64'h0, 64'h1, 1'b1, 1);
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    beat(rep(8'd1), rep(8'd10), rep(8'd4), 1'b1, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    #1;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("bp_g_hold", 64'(g), 64'd48);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    beat(rep(8'd1), rep(8'd3), rep(8'd1), 1'b1, 0);
    wait_drain();

    // Enable low mid-batch
    beat(rep(8'd2), rep(8'd5), rep(8'd9), 1'b0, 0);
    enable = 1'b0;
    #1;
    check("en_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    beat(rep(8'd2), rep(8'd5), rep(8'd9), 1'b1, 0);
    wait_drain();

    // Reset mid-batch discards partial sums
    beat(rep(8'd1), rep(8'd10), rep(8'd4), 1'b0, 0);
    beat(rep(8'd1), rep(8'd10), rep(8'd4), 1'b0, 0);
    resetn = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_g", 64'(g), 64'd0);
    check("mrst_g_sat", 64'(g_sat), 64'd0);
    check("mrst_ovf", 64'(ovf), 64'd0);
    model_acc = 0;
    @(negedge clk);
    resetn = 1'b1;
    beat(rep(8'd1), rep(8'd3), rep(8'd1), 1'b1, 0);
    wait_drain();

    // Overflow on the 17th beat of one batch
    repeat (16) beat(64'h0, 64'h0, 64'h0, 1'b0, 0);
    check("ovf_16", 64'(ovf), 64'd0);
    beat(64'h0, 64'h0, 64'h0, 1'b0, 0);
    check("ovf_17", 64'(ovf), 64'd1);
    beat(64'h0, 64'h0, 64'h0, 1'b1, 0);
    wait_drain();
    repeat (3) @(negedge clk);
    check("ovf_sticky", 64'(ovf), 64'd1);
    resetn = 1'b0;
    #1;
    check("ovf_rst", 64'(ovf), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
